// File: rtl/uart_rx_frame_ctrl.sv
// Assembles SOF/ADDR/DATA/CHK command frames from the UART byte stream and
// issues a one-cycle write strobe for each frame whose checksum matches.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SOF           = 8'hAA,
  parameter int         TO_W          = 12,
  parameter int         TIMEOUT_TICKS = 640
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_err,
  output logic [7:0] o_err_cnt,
  output logic       o_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] CHK  = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            timeout_hit;

  // A byte arriving on the expiring tick takes priority over the timeout.
  assign timeout_hit = (state_q != IDLE) && baud_tick && !i_rx_done &&
                       (to_cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (i_rx_done) begin
      case (state_q)
        IDLE: if (i_rx_data == SOF) state_d = ADDR;
        ADDR: begin
          addr_d  = i_rx_data;
          state_d = DATA;
        end
        DATA: begin
          data_d  = i_rx_data;
          state_d = CHK;
        end
        default: begin
          state_d = IDLE;
          if (i_rx_data == (addr_q ^ data_q)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
          end else begin
            frame_err_d = 1'b1;
            err_cnt_d   = sat_inc(err_cnt_q);
          end
        end
      endcase
    end else if (timeout_hit) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      err_cnt_d   = sat_inc(err_cnt_q);
    end

    if ((state_q == IDLE) || i_rx_done || timeout_hit) begin
      to_cnt_d = '0;
    end else if (baud_tick) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      to_cnt_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      to_cnt_q    <= to_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_frame_err = frame_err_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: commits, checksum errors, junk,
// timeouts, saturation and mid-frame reset.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_done = 1'b0;
  logic       o_wr_en;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_frame_err;
  logic [7:0] o_err_cnt;
  logic       o_busy;

  int asserts = 0;
  int fails   = 0;
  logic [7:0] exp_err = 8'h00;

  uart_rx_frame_ctrl dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_frame_err(o_frame_err), .o_err_cnt(o_err_cnt), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Strobe and error must never be high together.
  always @(negedge clk) begin
    if (reset) begin
      asserts++;
      if (o_wr_en && o_frame_err) begin
        fails++;
        $display("FAIL excl: wr_en=%b frame_err=%b required not both 1", o_wr_en, o_frame_err);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge clk); #1;
    i_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    baud_tick = 1'b1;
    @(posedge clk); #1;
    baud_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    asserts++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_frame_err, o_err_cnt, o_busy} !== 27'd0) begin
      fails++;
      $display("FAIL reset_outs: got en=%b a=%h d=%h err=%b cnt=%h busy=%b required all 0",
               o_wr_en, o_wr_addr, o_wr_data, o_frame_err, o_err_cnt, o_busy);
    end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_valid_frame();
    send_byte(8'hAA);
    asserts++;
    if (o_busy !== 1'b1) begin fails++; $display("FAIL valid_busy1: got %b required 1", o_busy); end
    idle(199);
    send_byte(8'h12);
    idle(199);
    send_byte(8'h34);
    asserts++;
    if (o_busy !== 1'b1 || o_wr_en !== 1'b0) begin
      fails++; $display("FAIL valid_busy3: busy=%b wr_en=%b required 1/0", o_busy, o_wr_en);
    end
    idle(199);
    send_byte(8'h26);
    asserts++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 8'h12 || o_wr_data !== 8'h34) begin
      fails++; $display("FAIL valid_commit: en=%b a=%h d=%h required 1/12/34", o_wr_en, o_wr_addr, o_wr_data);
    end
    asserts++;
    if (o_busy !== 1'b0 || o_err_cnt !== 8'h00 || o_frame_err !== 1'b0) begin
      fails++; $display("FAIL valid_state: busy=%b cnt=%h ferr=%b required 0/00/0", o_busy, o_err_cnt, o_frame_err);
    end
    idle(1);
    asserts++;
    if (o_wr_en !== 1'b0) begin fails++; $display("FAIL valid_pulse: wr_en=%b required 0", o_wr_en); end
  endtask

  task automatic test_bad_checksum();
    send_byte(8'hAA); idle(3);
    send_byte(8'h12); idle(3);
    send_byte(8'h34); idle(3);
    send_byte(8'h00);
    exp_err = exp_err + 8'd1;
    asserts++;
    if (o_frame_err !== 1'b1 || o_wr_en !== 1'b0 || o_err_cnt !== exp_err) begin
      fails++; $display("FAIL bad_err: ferr=%b en=%b cnt=%h required 1/0/%h", o_frame_err, o_wr_en, o_err_cnt, exp_err);
    end
    asserts++;
    if (o_wr_addr !== 8'h12 || o_wr_data !== 8'h34) begin
      fails++; $display("FAIL bad_hold: a=%h d=%h required 12/34", o_wr_addr, o_wr_data);
    end
    idle(1);
    asserts++;
    if (o_frame_err !== 1'b0) begin fails++; $display("FAIL bad_pulse: ferr=%b required 0", o_frame_err); end
  endtask

  task automatic test_junk();
    send_byte(8'h55); idle(2);
    send_byte(8'h00); idle(2);
    asserts++;
    if (o_busy !== 1'b0 || o_frame_err !== 1'b0 || o_err_cnt !== exp_err) begin
      fails++; $display("FAIL junk_idle: busy=%b ferr=%b cnt=%h required 0/0/%h", o_busy, o_frame_err, o_err_cnt, exp_err);
    end
    send_byte(8'hAA); idle(2);
    send_byte(8'hAA); idle(2);
    send_byte(8'h01); idle(2);
    send_byte(8'hAB);
    asserts++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 8'hAA || o_wr_data !== 8'h01) begin
      fails++; $display("FAIL junk_commit: en=%b a=%h d=%h required 1/AA/01", o_wr_en, o_wr_addr, o_wr_data);
    end
    idle(2);
  endtask

  task automatic test_timeout();
    send_byte(8'hAA); idle(2);
    send_byte(8'h12); idle(2);
    repeat (639) tick();
    asserts++;
    if (o_busy !== 1'b1 || o_frame_err !== 1'b0) begin
      fails++; $display("FAIL to_early: busy=%b ferr=%b required 1/0", o_busy, o_frame_err);
    end
    tick();
    exp_err = exp_err + 8'd1;
    asserts++;
    if (o_frame_err !== 1'b1 || o_busy !== 1'b0 || o_err_cnt !== exp_err) begin
      fails++; $display("FAIL to_fire: ferr=%b busy=%b cnt=%h required 1/0/%h", o_frame_err, o_busy, o_err_cnt, exp_err);
    end
    idle(1);
    asserts++;
    if (o_frame_err !== 1'b0) begin fails++; $display("FAIL to_pulse: ferr=%b required 0", o_frame_err); end
    send_byte(8'hAA); send_byte(8'h0F); send_byte(8'hF0); send_byte(8'hFF);
    asserts++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 8'h0F || o_wr_data !== 8'hF0) begin
      fails++; $display("FAIL to_recover: en=%b a=%h d=%h required 1/0F/F0", o_wr_en, o_wr_addr, o_wr_data);
    end
    idle(2);
  endtask

  task automatic test_coincidence();
    send_byte(8'hAA); idle(2);
    send_byte(8'h12); idle(2);
    repeat (639) tick();
    @(posedge clk); #1;
    baud_tick = 1'b1;
    i_rx_data = 8'h34;
    i_rx_done = 1'b1;
    @(posedge clk); #1;
    baud_tick = 1'b0;
    i_rx_done = 1'b0;
    asserts++;
    if (o_frame_err !== 1'b0 || o_busy !== 1'b1 || o_err_cnt !== exp_err) begin
      fails++; $display("FAIL coin_noerr: ferr=%b busy=%b cnt=%h required 0/1/%h", o_frame_err, o_busy, o_err_cnt, exp_err);
    end
    send_byte(8'h26);
    asserts++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 8'h12 || o_wr_data !== 8'h34) begin
      fails++; $display("FAIL coin_commit: en=%b a=%h d=%h required 1/12/34", o_wr_en, o_wr_addr, o_wr_data);
    end
    idle(2);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
    end
    asserts++;
    if (o_err_cnt !== 8'hFF || exp_err !== 8'hFF) begin
      fails++; $display("FAIL sat_cnt: cnt=%h required FF", o_err_cnt);
    end
    asserts++;
    if (o_wr_addr !== 8'h12 || o_wr_data !== 8'h34) begin
      fails++; $display("FAIL sat_hold: a=%h d=%h required 12/34", o_wr_addr, o_wr_data);
    end
    idle(2);
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hAA); send_byte(8'h12);
    #3 reset = 1'b0;
    #1;
    asserts++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_frame_err, o_err_cnt, o_busy} !== 27'd0) begin
      fails++; $display("FAIL rst_mid: en=%b a=%h d=%h ferr=%b cnt=%h busy=%b required all 0",
                        o_wr_en, o_wr_addr, o_wr_data, o_frame_err, o_err_cnt, o_busy);
    end
    idle(2);
    reset = 1'b1;
    idle(2);
    send_byte(8'hAA); send_byte(8'h5A); send_byte(8'hA5); send_byte(8'hFF);
    asserts++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 8'h5A || o_wr_data !== 8'hA5 || o_err_cnt !== 8'h00) begin
      fails++; $display("FAIL rst_recover: en=%b a=%h d=%h cnt=%h required 1/5A/A5/00",
                        o_wr_en, o_wr_addr, o_wr_data, o_err_cnt);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_junk();
    test_timeout();
    test_coincidence();
    test_saturation();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
